// File: rtl/fp32_pkg.sv
// fp32_pkg: shared IEEE-754 single-precision field slices, constants and converter states
package fp32_pkg;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int FRAC_MSB = 22;
  localparam logic [7:0] BIAS = 8'd127;
  localparam logic [7:0] EXP_MAX = 8'd255;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  typedef enum logic [1:0] {IDLE, SHIFT, SIGN, DONE} state_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: combinational special-case detection and shift setup for a packed float
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] in_data,
  output logic        is_nan,
  output logic        is_ovf,
  output logic        is_zero_res,
  output logic        shift_left,
  output logic [4:0]  shift_amt,
  output logic [23:0] mant
);
  logic [7:0] e_raw;
  logic [22:0] frac;
  logic [7:0] lpos;
  logic [7:0] rpos;
  assign e_raw = in_data[EXP_MSB:EXP_LSB];
  assign frac = in_data[FRAC_MSB:0];
  assign mant = {e_raw != 8'd0, frac};
  assign is_nan = (e_raw == EXP_MAX) && (frac != 23'd0);
  assign is_ovf = !is_nan && (e_raw >= BIAS + 8'd31);
  assign is_zero_res = e_raw < BIAS;
  // the integer point sits 23 bits above the mantissa LSB
  assign shift_left = e_raw >= BIAS + 8'd23;
  assign lpos = e_raw - (BIAS + 8'd23);
  assign rpos = (BIAS + 8'd23) - e_raw;
  assign shift_amt = shift_left ? lpos[4:0] : rpos[4:0];
endmodule

// File: rtl/fp32_to_int_seq.sv
// fp32_to_int_seq: multi-cycle float-to-int32 converter, truncating, with an iterative shifter
module fp32_to_int_seq
  import fp32_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_invalid
);
  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  state_t state_q, state_d;
  logic [31:0] mag_q, mag_d, data_q, data_d;
  logic [4:0] rem_q, rem_d, step;
  logic left_q, left_d, sign_q, sign_d, inv_q, inv_d;
  logic is_nan, is_ovf, is_zero_res, shift_left;
  logic [4:0] shift_amt;
  logic [23:0] mant;
  fp32_classify u_cls (
    .in_data(in_data),
    .is_nan(is_nan),
    .is_ovf(is_ovf),
    .is_zero_res(is_zero_res),
    .shift_left(shift_left),
    .shift_amt(shift_amt),
    .mant(mant)
  );
  assign in_ready = (state_q == IDLE) && !rst;
  assign out_valid = state_q == DONE;
  assign out_data = data_q;
  assign out_invalid = inv_q;
  assign step = (rem_q < STEP) ? rem_q : STEP;
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    rem_d = rem_q;
    left_d = left_q;
    sign_d = sign_q;
    data_d = data_q;
    inv_d = inv_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        sign_d = in_data[SIGN_BIT];
        mag_d = {8'd0, mant};
        rem_d = shift_amt;
        left_d = shift_left;
        if (is_nan) begin
          data_d = INT_MIN;
          inv_d = 1'b1;
          state_d = DONE;
        end else if (is_ovf) begin
          data_d = in_data[SIGN_BIT] ? INT_MIN : INT_MAX;
          inv_d = in_data != INT_MIN + 32'h4F00_0000;
          state_d = DONE;
        end else if (is_zero_res) begin
          data_d = 32'd0;
          inv_d = 1'b0;
          state_d = DONE;
        end else begin
          state_d = (shift_amt == 5'd0) ? SIGN : SHIFT;
        end
      end
      SHIFT: begin
        mag_d = left_q ? mag_q << step : mag_q >> step;
        rem_d = rem_q - step;
        state_d = (rem_d == 5'd0) ? SIGN : SHIFT;
      end
      SIGN: begin
        data_d = sign_q ? -mag_q : mag_q;
        inv_d = 1'b0;
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q <= 32'd0;
      rem_q <= 5'd0;
      left_q <= 1'b0;
      sign_q <= 1'b0;
      data_q <= 32'd0;
      inv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      rem_q <= rem_d;
      left_q <= left_d;
      sign_q <= sign_d;
      data_q <= data_d;
      inv_q <= inv_d;
    end
  end
endmodule

// File: tb/tb_fp32_to_int_seq.sv
// tb_fp32_to_int_seq: directed vector table plus back-pressure and mid-operation reset sequences
module tb_fp32_to_int_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_data = 32'd0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  logic out_invalid;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fp32_to_int_seq #(.SHIFT_STEP(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_invalid(out_invalid)
  );
  typedef struct {
    logic [31:0] din;
    logic [31:0] dout;
    logic        inv;
    int          lat;
  } vec_t;
  vec_t vecs[16];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic start(input logic [31:0] d);
    int g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 32'hDEAD_BEEF;
  endtask
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic run(input int k, input vec_t v);
    int lat;
    start(v.din);
    wait_valid(lat);
    chk($sformatf("v%0d_data", k), out_data, v.dout);
    chk($sformatf("v%0d_inv", k), 32'(out_invalid), 32'(v.inv));
    chk($sformatf("v%0d_lat", k), 32'(lat), 32'(v.lat));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_idle", k), 32'(out_valid), 32'd0);
  endtask
  initial begin
    int lat;
    int seen;
    logic [31:0] held;
    vecs[0] = '{32'h3F80_0000, 32'h0000_0001, 1'b0, 8};
    vecs[1] = '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 8};
    vecs[2] = '{32'h4B80_0001, 32'h0100_0002, 1'b0, 3};
    vecs[3] = '{32'hCF00_0000, 32'h8000_0000, 1'b0, 1};
    vecs[4] = '{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[5] = '{32'h7FC0_0000, 32'h8000_0000, 1'b1, 1};
    vecs[6] = '{32'h3F00_0000, 32'h0000_0000, 1'b0, 1};
    vecs[7] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 1};
    vecs[8] = '{32'h0000_0001, 32'h0000_0000, 1'b0, 1};
    vecs[9] = '{32'hFF80_0000, 32'h8000_0000, 1'b1, 1};
    vecs[10] = '{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1};
    vecs[11] = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 4};
    vecs[12] = '{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 4};
    vecs[13] = '{32'h4B00_0000, 32'h0080_0000, 1'b0, 2};
    vecs[14] = '{32'h4049_0FDB, 32'h0000_0003, 1'b0, 8};
    vecs[15] = '{32'hCF00_0001, 32'h8000_0000, 1'b1, 1};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_invalid", 32'(out_invalid), 32'd0);
    chk("rst_in_ready_after", 32'(in_ready), 32'd1);
    for (int i = 0; i < 16; i++) run(i, vecs[i]);
    out_ready = 1'b0;
    start(32'hC020_0000);
    wait_valid(lat);
    chk("bp_lat", 32'(lat), 32'd8);
    held = out_data;
    chk("bp_data", held, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("bp_stable_%0d", i), out_data, held);
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    start(32'h3F80_0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mid_rst_no_stale", 32'(seen), 32'd0);
    run(99, '{32'hC020_0000, 32'hFFFF_FFFE, 1'b0, 8});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
